// File: rtl/des_pkg.sv
// des_pkg: shared types, FIPS 46-3 permutation tables and a generic
// table-driven permute helper for the DES permutation pipeline.
//   des_block_t        64-bit block. FIPS bit 1 is [63] and bit 64 is [0].
//   des_perm_mode_e    selects the initial (IP) or the final (IP^-1) permutation.
//   DES_IP_TABLE/FP    1-based FIPS source-bit tables.
//   des_permute()      out bit i = in bit tbl[i], both numbered MSB-first.
package des_pkg;

  typedef logic [63:0] des_block_t;

  typedef enum logic {
    DES_MODE_IP = 1'b0,
    DES_MODE_FP = 1'b1
  } des_perm_mode_e;

  typedef int unsigned des_table_t [64];

  localparam des_table_t DES_IP_TABLE = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam des_table_t DES_FP_TABLE = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  // Table entry i (0-based) names the 1-based source bit for output bit i+1.
  // In vector index form: out[63-i] = block[64-tbl[i]].
  function automatic des_block_t des_permute(input des_block_t block,
                                             input des_table_t tbl);
    des_block_t res;
    logic [5:0] dst;
    logic [5:0] src;
    res = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      dst      = 6'(63 - i);
      src      = 6'(64 - tbl[i]);
      res[dst] = block[src];
    end
    return res;
  endfunction

endpackage

// File: rtl/des_pipe_slice.sv
// des_pipe_slice: one pipeline register stage holding {valid, data, tag}.
//   clk, rst     rising-edge clock, synchronous active-high reset
//   load_valid   upstream beat present (input port or previous stage)
//   load_data    upstream block
//   load_tag     upstream sideband tag
//   advance      downstream takes this stage's beat this cycle
//   accept       this stage loads this cycle (empty or advancing)
//   valid/data/tag  registered stage contents
import des_pkg::*;

module des_pipe_slice #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  des_block_t       load_data,
  input  logic [TAG_W-1:0] load_tag,
  input  logic             advance,
  output logic             accept,
  output logic             valid,
  output des_block_t       data,
  output logic [TAG_W-1:0] tag
);

  // An empty stage always loads, so bubbles collapse toward the output.
  assign accept = !valid || advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      tag   <= '0;
    end else if (accept) begin
      valid <= load_valid;
      // Payload registers only move with a real beat.
      if (load_valid) begin
        data <= load_data;
        tag  <= load_tag;
      end
    end
  end

endmodule

// File: rtl/des_perm_pipe.sv
// des_perm_pipe: pipelined DES initial/final permutation with valid/ready.
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  input handshake (in_ready is combinational)
//   in_mode            0 = IP, 1 = FP (IP^-1)
//   in_swap            exchange 32-bit halves before FP; ignored for IP
//   in_data, in_tag    input block and sideband tag
//   out_valid/out_ready  output handshake
//   out_data, out_tag  permuted block and its tag
// PIPE_STAGES (1..4) register stages; latency equals PIPE_STAGES with no stall.
import des_pkg::*;

module des_perm_pipe #(
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic             in_swap,
  input  logic [63:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("des_perm_pipe: PIPE_STAGES must be in 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("des_perm_pipe: TAG_W must be at least 1");
  end

  des_perm_mode_e mode;
  des_block_t     perm_src;
  des_block_t     perm_data;

  assign mode = des_perm_mode_e'(in_mode);

  always_comb begin
    perm_src = in_data;
    if (mode == DES_MODE_FP && in_swap) begin
      perm_src = {in_data[31:0], in_data[63:32]};
    end
    perm_data = (mode == DES_MODE_FP) ? des_permute(perm_src, DES_FP_TABLE)
                                      : des_permute(perm_src, DES_IP_TABLE);
  end

  logic [PIPE_STAGES-1:0] up_valid;
  logic [PIPE_STAGES-1:0] stage_valid;
  logic [PIPE_STAGES-1:0] stage_accept;
  logic [PIPE_STAGES-1:0] stage_advance;
  des_block_t             up_data    [PIPE_STAGES];
  des_block_t             stage_data [PIPE_STAGES];
  logic [TAG_W-1:0]       up_tag     [PIPE_STAGES];
  logic [TAG_W-1:0]       stage_tag  [PIPE_STAGES];

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_valid[k] = in_valid;
      assign up_data[k]  = perm_data;
      assign up_tag[k]   = in_tag;
    end else begin : g_body
      assign up_valid[k] = stage_valid[k-1];
      assign up_data[k]  = stage_data[k-1];
      assign up_tag[k]   = stage_tag[k-1];
    end

    // Ready ripples back from the output: a stage advances when the next
    // one will load this cycle.
    if (k == PIPE_STAGES - 1) begin : g_tail
      assign stage_advance[k] = out_ready;
    end else begin : g_link
      assign stage_advance[k] = stage_accept[k+1];
    end

    des_pipe_slice #(
      .TAG_W(TAG_W)
    ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .load_valid(up_valid[k]),
      .load_data (up_data[k]),
      .load_tag  (up_tag[k]),
      .advance   (stage_advance[k]),
      .accept    (stage_accept[k]),
      .valid     (stage_valid[k]),
      .data      (stage_data[k]),
      .tag       (stage_tag[k])
    );
  end

  assign in_ready  = stage_accept[0];
  assign out_valid = stage_valid[PIPE_STAGES-1];
  assign out_data  = stage_data[PIPE_STAGES-1];
  assign out_tag   = stage_tag[PIPE_STAGES-1];

endmodule

// File: tb/tb_des_perm_pipe.sv
// tb_des_perm_pipe: directed checks of des_perm_pipe built with 1, 2 and 4
// stages side by side; each scenario runs against one instance at a time
// while the others stay idle.
module tb_des_perm_pipe;
  import des_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic       in_mode   [3];
  logic       in_swap   [3];
  logic [63:0] in_data  [3];
  logic [3:0] in_tag    [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [63:0] out_data [3];
  logic [3:0] out_tag   [3];

  int unsigned stages [3] = '{1, 2, 4};
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Bench-side IP table; the FP table is derived as its inverse.
  int unsigned ip_tab [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };
  int unsigned fp_tab [64];

  des_perm_pipe #(.PIPE_STAGES(1), .TAG_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_mode(in_mode[0]), .in_swap(in_swap[0]), .in_data(in_data[0]), .in_tag(in_tag[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_tag(out_tag[0]));

  des_perm_pipe #(.PIPE_STAGES(2), .TAG_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_mode(in_mode[1]), .in_swap(in_swap[1]), .in_data(in_data[1]), .in_tag(in_tag[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_tag(out_tag[1]));

  des_perm_pipe #(.PIPE_STAGES(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_mode(in_mode[2]), .in_swap(in_swap[2]), .in_data(in_data[2]), .in_tag(in_tag[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .out_tag(out_tag[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output must hold while stalled.
  for (genvar g = 0; g < 3; g++) begin : g_sva
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid[g] && !out_ready[g]) |=>
        (out_valid[g] && $stable(out_data[g]) && $stable(out_tag[g])))
      else begin
        n_errors++;
        $display("FAIL stall_stable dut%0d: out_* changed while stalled", g);
      end
  end

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic des_block_t ref_perm(input des_block_t d, input logic mode, input logic swap);
    des_block_t  x;
    des_block_t  r;
    int unsigned t;
    x = (mode && swap) ? {d[31:0], d[63:32]} : d;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      t = mode ? fp_tab[i] : ip_tab[i];
      r[6'(63 - i)] = x[6'(64 - t)];
    end
    return r;
  endfunction

  function automatic des_block_t beat_data(input int unsigned i);
    return {32'h0F1E2D3C ^ (32'(i) * 32'h01010101), 32'h89ABCDEF + 32'(i) * 32'h11111111};
  endfunction

  task automatic run_single(input int unsigned u, input logic mode, input logic swap,
                            input des_block_t d, input logic [3:0] tg,
                            input des_block_t exp, input string name);
    int unsigned lat;
    string pfx;
    pfx = $sformatf("dut%0d_%s", stages[u], name);
    @(posedge clk); #1;
    in_valid[u] = 1'b1; in_mode[u] = mode; in_swap[u] = swap;
    in_data[u] = d; in_tag[u] = tg; out_ready[u] = 1'b1;
    @(negedge clk);
    check_eq({pfx, "_in_ready"}, 64'(in_ready[u]), 64'd1);
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    lat = 0;
    do begin
      lat++;
      @(negedge clk);
    end while (!out_valid[u] && lat < 20);
    check_eq({pfx, "_latency"}, 64'(lat), 64'(stages[u]));
    check_eq({pfx, "_data"}, out_data[u], exp);
    check_eq({pfx, "_tag"}, 64'(out_tag[u]), 64'(tg));
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({pfx, "_drained"}, 64'(out_valid[u]), 64'd0);
  endtask

  task automatic run_stream(input int unsigned u);
    des_block_t  exp_q[$];
    logic [3:0]  tag_q[$];
    int unsigned sent, rcvd, occ, cyc;
    logic        in_fire, out_fire, exp_rdy;
    des_block_t  e_data;
    logic [3:0]  e_tag;
    string       pfx;
    pfx = $sformatf("dut%0d_stream", stages[u]);
    sent = 0; rcvd = 0; occ = 0; cyc = 0;
    @(posedge clk); #1;
    while (rcvd < 16 && cyc < 400) begin
      in_valid[u] = (sent < 16);
      in_mode[u]  = sent[0];
      in_swap[u]  = sent[1];
      in_data[u]  = beat_data(sent);
      in_tag[u]   = sent[3:0];
      out_ready[u] = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      exp_rdy = !(occ == stages[u] && !out_ready[u]);
      check_eq({pfx, "_in_ready"}, 64'(in_ready[u]), 64'(exp_rdy));
      in_fire  = in_valid[u] && in_ready[u];
      out_fire = out_valid[u] && out_ready[u];
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          check_eq({pfx, "_spurious"}, 64'd1, 64'(exp_q.size()));
        end else begin
          e_data = exp_q.pop_front();
          e_tag  = tag_q.pop_front();
          check_eq({pfx, "_data"}, out_data[u], e_data);
          check_eq({pfx, "_tag"}, 64'(out_tag[u]), 64'(e_tag));
        end
        rcvd++;
        occ--;
      end
      if (in_fire) begin
        exp_q.push_back(ref_perm(beat_data(sent), sent[0], sent[1]));
        tag_q.push_back(sent[3:0]);
        sent++;
        occ++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({pfx, "_count"}, 64'(rcvd), 64'd16);
    in_valid[u] = 1'b0;
    out_ready[u] = 1'b1;
  endtask

  task automatic run_reset(input int unsigned u);
    logic  seen;
    string pfx;
    pfx = $sformatf("dut%0d_reset", stages[u]);
    @(posedge clk); #1;
    out_ready[u] = 1'b0; in_valid[u] = 1'b1; in_mode[u] = 1'b0; in_swap[u] = 1'b0;
    in_data[u] = 64'hDEADBEEF00000001; in_tag[u] = 4'h9;
    @(posedge clk); #1;
    in_data[u] = 64'hDEADBEEF00000002; in_tag[u] = 4'hA;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid[u] = 1'b0;
    @(negedge clk);
    check_eq({pfx, "_out_valid"}, 64'(out_valid[u]), 64'd0);
    check_eq({pfx, "_in_ready"}, 64'(in_ready[u]), 64'd1);
    check_eq({pfx, "_out_data"}, out_data[u], 64'd0);
    check_eq({pfx, "_out_tag"}, 64'(out_tag[u]), 64'd0);
    out_ready[u] = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[u]) seen = 1'b1;
    end
    check_eq({pfx, "_no_ghost"}, 64'(seen), 64'd0);
  endtask

  initial begin
    for (int unsigned i = 0; i < 64; i++) fp_tab[ip_tab[i] - 1] = i + 1;
    for (int unsigned u = 0; u < 3; u++) begin
      in_valid[u] = 1'b0; in_mode[u] = 1'b0; in_swap[u] = 1'b0;
      in_data[u] = '0; in_tag[u] = '0; out_ready[u] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int unsigned u = 0; u < 3; u++) begin
      check_eq($sformatf("dut%0d_init_out_valid", stages[u]), 64'(out_valid[u]), 64'd0);
      check_eq($sformatf("dut%0d_init_in_ready", stages[u]), 64'(in_ready[u]), 64'd1);
      check_eq($sformatf("dut%0d_init_out_data", stages[u]), out_data[u], 64'd0);
    end

    // Sanity of the bench model against the published vectors.
    check_eq("model_ip", ref_perm(64'h0123456789ABCDEF, 1'b0, 1'b0), 64'hCC00CCFFF0AAF0AA);
    check_eq("model_fp", ref_perm(64'hCC00CCFFF0AAF0AA, 1'b1, 1'b0), 64'h0123456789ABCDEF);

    for (int unsigned u = 0; u < 3; u++) begin
      run_single(u, 1'b0, 1'b0, 64'h0123456789ABCDEF, 4'h5, 64'hCC00CCFFF0AAF0AA, "ip");
      run_single(u, 1'b0, 1'b1, 64'h0123456789ABCDEF, 4'hA, 64'hCC00CCFFF0AAF0AA, "ip_swap_ignored");
      run_single(u, 1'b1, 1'b0, 64'hCC00CCFFF0AAF0AA, 4'h3, 64'h0123456789ABCDEF, "fp");
      run_single(u, 1'b0, 1'b0, 64'h0000000000000001, 4'hF, 64'h0000008000000000, "ip_bit64");
      run_single(u, 1'b1, 1'b0, 64'h8000000000000000, 4'h1, 64'h0000000000000040, "fp_bit1");
      run_single(u, 1'b1, 1'b1, 64'h0000000080000000, 4'h6, 64'h0000000000000040, "fp_swap");
      run_stream(u);
      run_reset(u);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
